simd_booth_mult_seq: RTL and testbench
======================================

SIMD_BOOTH_MULT_SEQ -- requirements
Module: simd_booth_mult_seq

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning full operand width; legal values are multiples of 4 and at least 8.
REQ-002 The block SHALL have parameter MODE_RSVD_AS_FULL, default 1, meaning mode 2'b11 is executed as mode 2'b00 (1) or rejected by holding in_ready low (0).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1, meaning synchronous active-low reset.
REQ-005 The block SHALL have port mode, input, 2, meaning lane split: 00 = 1 lane of W, 01 = 2 lanes of W/2, 10 = 4 lanes of W/4.
REQ-006 The block SHALL have port in_valid, input, 1, meaning operands and mode are valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block can accept a new operation.
REQ-008 The block SHALL have port M, input, W, meaning multiplicand, packed lanes with lane 0 in the LSBs.
REQ-009 The block SHALL have port Q, input, W, meaning multiplier, packed the same way as M.
REQ-010 The block SHALL have port out_valid, output, 1, meaning result is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-012 The block SHALL have port result, output, 2W, meaning packed per-lane products; lane i of width L occupies bits [2L(i+1)-1 : 2Li].
REQ-013 The block SHALL have port busy, output, 1, meaning the state is RUN or DONE.

Function
REQ-014 Each lane SHALL compute the signed two's-complement product of its L-bit M and Q slices, where L = W / lane count.
REQ-015 The block SHALL use a three-state FSM with states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 An operation SHALL be accepted when in_valid and in_ready are both 1; mode, M and Q SHALL be captured at that edge and the FSM SHALL enter RUN.
REQ-017 Changes on mode, M or Q after acceptance SHALL have no effect on the running operation.
REQ-018 Each RUN cycle SHALL perform one radix-2 Booth step per lane, all lanes in parallel:
- examine the pair {Q[0], q_-1};
- on 01 add M, on 10 subtract M, otherwise no change;
- arithmetic-shift {A, Q, q_-1} right by 1.
REQ-019 Lane accumulators SHALL be L+1 bits wide so that subtracting the most-negative M is exact; no carry or shift SHALL cross a lane boundary.
REQ-020 An iteration counter SHALL be loaded with L at acceptance; RUN SHALL last exactly L cycles, so a result accepted at edge t has out_valid = 1 after edge t+L.
REQ-021 On leaving RUN the FSM SHALL enter DONE with out_valid = 1; result SHALL be registered and held stable while out_valid = 1 and out_ready = 0.
REQ-022 In DONE, out_ready = 1 SHALL return the FSM to IDLE at that edge with out_valid falling; result SHALL retain its last value.
REQ-023 If out_ready is already 1 when DONE is entered, the handshake SHALL complete at the first edge in DONE.
REQ-024 in_valid while busy SHALL be ignored; no operation is queued.
REQ-025 When MODE_RSVD_AS_FULL = 0 and mode = 11, in_ready SHALL be 0 and no operation SHALL be accepted.

Reset
REQ-026 When clr_n = 0 at a clock edge, the FSM SHALL go to IDLE, the counter and all datapath registers SHALL clear to 0, and any in-flight operation SHALL be discarded.
REQ-027 Reset values SHALL be: in_ready = 1, out_valid = 0, busy = 0, result = 0.
REQ-028 Reset SHALL take priority over every other event, including a simultaneous input or output handshake.

Configuration
REQ-029 With macro SIMD_BOOTH_ZERO_BYPASS_EN defined, an accepted operation in which every lane has M slice = 0 or Q slice = 0 SHALL skip RUN and enter DONE with result = 0, so out_valid = 1 after edge t+1.
REQ-030 Without SIMD_BOOTH_ZERO_BYPASS_EN, all operations SHALL take the full L-cycle RUN, including zero operands.

Verification (W=16)
REQ-031 The bench SHALL cover mode 00, M=16'h8000, Q=16'h8000: result = 32'h40000000, with out_valid first seen 16 cycles after acceptance.
REQ-032 The bench SHALL cover mode 01, M=16'hFD07, Q=16'h05FE: result = 32'hFFF1FFF2 (lane products -15 and -14) after 8 cycles.
REQ-033 The bench SHALL cover mode 10, M=16'h781F, Q=16'h78F1: result = 32'h3140FFFF (lane products 49, 64, -1, -1) after 4 cycles.
REQ-034 The bench SHALL hold out_ready = 0 for 5 cycles in DONE: result and out_valid stay stable and in_ready stays 0, with a single transfer when out_ready = 1.
REQ-035 The bench SHALL assert clr_n = 0 in the 3rd RUN cycle of a mode 00 operation: next cycle shows IDLE state, in_ready = 1, result = 0, and no out_valid pulse.
REQ-036 The bench SHALL cover mode 00 with M=0 and Q=16'h1234: with SIMD_BOOTH_ZERO_BYPASS_EN, out_valid after 1 cycle with result 0; without it, after 16 cycles with result 0.

Source files
------------

// File: rtl/simd_booth_mult_seq.sv
// Sequential SIMD radix-2 Booth multiplier: 1, 2 or 4 signed lanes packed in a W-bit operand pair.
// Optional macro SIMD_BOOTH_ZERO_BYPASS_EN: operations with a zero factor in every lane finish after one cycle.
module simd_booth_mult_seq #(
    parameter int W                 = 16,
    parameter int MODE_RSVD_AS_FULL = 1
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [1:0]     mode,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   M,
    input  logic [W-1:0]   Q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           busy
);

    localparam int            CW      = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [CW-1:0]  cnt_r;
    logic [1:0]     lsh_r;
    logic [W:0]     a_r [4];
    logic [W:0]     m_r [4];
    logic [W-1:0]   q_r [4];
    logic [3:0]     qm1_r;
    logic [2*W-1:0] result_r;

    logic [W:0]     a_nxt_s [4];
    logic [W-1:0]   q_nxt_s [4];
    logic [3:0]     qm1_nxt_s;
    logic [2*W-1:0] pack_s;
    logic [1:0]     acc_lsh_s;
    logic           rsvd_block_s;
    logic           in_ready_s;
    logic           accept_s;
    logic           bypass_s;

    // lsh is log2 of the lane count; mode 11 falls through to a single full-width lane.
    function automatic logic [1:0] lane_shift(input logic [1:0] md);
        logic [1:0] s;
        case (md)
            2'b01:   s = 2'b01;
            2'b10:   s = 2'b10;
            default: s = 2'b00;
        endcase
        return s;
    endfunction

    function automatic int lane_len(input logic [1:0] lsh);
        return W >> lsh;
    endfunction

    function automatic int lane_cnt(input logic [1:0] lsh);
        return 1 << lsh;
    endfunction

    function automatic logic [W-1:0] zext_slice(input logic [W-1:0] vec, input int idx,
                                                input logic [1:0] lsh);
        int len;
        len = lane_len(lsh);
        return (vec >> (idx * len)) & ({W{1'b1}} >> (W - len));
    endfunction

    function automatic logic [W:0] sext_slice(input logic [W-1:0] vec, input int idx,
                                              input logic [1:0] lsh);
        logic [W:0] v;
        logic [W:0] hi;
        logic       sgn;
        int         len;
        len = lane_len(lsh);
        v   = {1'b0, zext_slice(vec, idx, lsh)};
        sgn = |(v & ({{W{1'b0}}, 1'b1} << (len - 1)));
        hi  = {(W+1){1'b1}} << len;
        return sgn ? (v | hi) : v;
    endfunction

    assign acc_lsh_s    = lane_shift(mode);
    assign rsvd_block_s = (mode == 2'b11) && (MODE_RSVD_AS_FULL == 0);
    assign in_ready_s   = (state_r == IDLE) && !rsvd_block_s;
    assign accept_s     = in_valid && in_ready_s;

`ifdef SIMD_BOOTH_ZERO_BYPASS_EN
    // Bypass when every active lane has a zero factor.
    always_comb begin
        bypass_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((i < lane_cnt(acc_lsh_s)) &&
                (zext_slice(M, i, acc_lsh_s) != {W{1'b0}}) &&
                (zext_slice(Q, i, acc_lsh_s) != {W{1'b0}})) begin
                bypass_s = 1'b0;
            end else begin
                bypass_s = bypass_s;
            end
        end
    end
`else
    assign bypass_s = 1'b0;
`endif

    // One Booth step per lane; lanes are independent so nothing carries between them.
    always_comb begin
        logic [W:0] sum;
        int         len;
        len       = lane_len(lsh_r);
        qm1_nxt_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sum = a_r[i];
            case ({q_r[i][0], qm1_r[i]})
                2'b01:   sum = a_r[i] + m_r[i];
                2'b10:   sum = a_r[i] - m_r[i];
                default: sum = a_r[i];
            endcase
            a_nxt_s[i]   = {sum[W], sum[W:1]};
            q_nxt_s[i]   = (q_r[i] >> 1) | ({{(W-1){1'b0}}, sum[0]} << (len - 1));
            qm1_nxt_s[i] = q_r[i][0];
        end
    end

    // Pack lane products {A[L-1:0], Q[L-1:0]} into 2L-bit result fields.
    always_comb begin
        logic [2*W-1:0] prod;
        int             len;
        len    = lane_len(lsh_r);
        pack_s = {(2*W){1'b0}};
        for (int i = 0; i < 4; i++) begin
            prod = ({{(W-1){a_nxt_s[i][W]}}, a_nxt_s[i]} << len) | {{W{1'b0}}, q_nxt_s[i]};
            prod = prod & ({(2*W){1'b1}} >> (2*W - 2*len));
            if (i < lane_cnt(lsh_r)) begin
                pack_s = pack_s | (prod << (2 * len * i));
            end else begin
                pack_s = pack_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, Booth iteration and result register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_r    <= {CW{1'b0}};
            lsh_r    <= 2'b00;
            qm1_r    <= 4'b0000;
            result_r <= {(2*W){1'b0}};
            for (int i = 0; i < 4; i++) begin
                a_r[i] <= {(W+1){1'b0}};
                m_r[i] <= {(W+1){1'b0}};
                q_r[i] <= {W{1'b0}};
            end
        end else if (state_r == IDLE) begin
            if (accept_s) begin
                // A bypassed operation runs one step on zeroed operands, which yields 0.
                lsh_r <= acc_lsh_s;
                cnt_r <= bypass_s ? CNT_ONE : CW'(lane_len(acc_lsh_s));
                qm1_r <= 4'b0000;
                for (int i = 0; i < 4; i++) begin
                    a_r[i] <= {(W+1){1'b0}};
                    m_r[i] <= bypass_s ? {(W+1){1'b0}} : sext_slice(M, i, acc_lsh_s);
                    q_r[i] <= bypass_s ? {W{1'b0}} : zext_slice(Q, i, acc_lsh_s);
                end
            end
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r - CNT_ONE;
            qm1_r <= qm1_nxt_s;
            for (int i = 0; i < 4; i++) begin
                a_r[i] <= a_nxt_s[i];
                q_r[i] <= q_nxt_s[i];
            end
            if (cnt_r == CNT_ONE) begin
                result_r <= pack_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign result    = result_r;

endmodule

// File: tb/tb_simd_booth_mult_seq.sv
// Self-checking bench for simd_booth_mult_seq (W=16): directed vectors plus random operations
// against an arithmetic lane-product model.
module tb_simd_booth_mult_seq;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] M;
    logic [15:0] Q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    simd_booth_mult_seq #(.W(16), .MODE_RSVD_AS_FULL(1)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .Q         (Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lanes_of(input logic [1:0] md);
        return (md == 2'b01) ? 2 : (md == 2'b10) ? 4 : 1;
    endfunction

    function automatic logic [15:0] lane_mask(input int len, input int i);
        return 16'(((32'd1 << len) - 32'd1) << (i * len));
    endfunction

    // Signed product of each lane's slices, placed in its 2L-bit result field.
    function automatic logic [31:0] model(input logic [1:0] md, input logic [15:0] m,
                                          input logic [15:0] q);
        int          n, len;
        longint      a, b, p, half, full;
        logic [63:0] acc, msk;
        n    = lanes_of(md);
        len  = 16 / n;
        half = longint'(1) << (len - 1);
        full = longint'(1) << len;
        acc  = 64'd0;
        for (int i = 0; i < n; i++) begin
            a = longint'((m & lane_mask(len, i)) >> (i * len));
            b = longint'((q & lane_mask(len, i)) >> (i * len));
            if (a >= half) a = a - full;
            if (b >= half) b = b - full;
            p   = a * b;
            msk = (64'd1 << (2 * len)) - 64'd1;
            acc = acc | ((64'(p) & msk) << (2 * len * i));
        end
        return acc[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] md, input logic [15:0] m,
                                     input logic [15:0] q);
        int n;
        int len;
        bit all_zero;
        n        = lanes_of(md);
        len      = 16 / n;
        all_zero = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (((m & lane_mask(len, i)) != 16'd0) && ((q & lane_mask(len, i)) != 16'd0))
                all_zero = 1'b0;
        end
`ifdef SIMD_BOOTH_ZERO_BYPASS_EN
        if (all_zero) return 1;
`endif
        return len;
    endfunction

    task automatic run_op(input logic [1:0] md, input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] exp_res, input int exp_lat, input int stall,
                          input string tag);
        int cyc;
        bit seen;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        mode      = md;
        M         = m;
        Q         = q;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick;
        in_valid = 1'b0;
        mode     = 2'($urandom);
        M        = 16'($urandom);
        Q        = 16'($urandom);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick;
            cyc++;
            seen = out_valid;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            tick;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_result"}, 64'(result), 64'(exp_res));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_retain"}, 64'(result), 64'(exp_res));
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  md;
        logic [15:0] m, q;
        int          pulses, n, len;

        clr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 2'b00; M = 16'd0; Q = 16'd0;
        tick;
        tick;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        clr_n = 1'b1;
        tick;

        run_op(2'b00, 16'h8000, 16'h8000, 32'h40000000, 16, 0, "full_min");
        run_op(2'b01, 16'hFD07, 16'h05FE, 32'hFFF1FFF2, 8, 2, "dual");
        run_op(2'b10, 16'h781F, 16'h78F1, 32'h3140FFFF, 4, 0, "quad");
        m = 16'($urandom);
        q = 16'($urandom) | 16'h0101;
        run_op(2'b01, m, q, model(2'b01, m, q), model_lat(2'b01, m, q), 5, "stall5");
        run_op(2'b00, 16'h0000, 16'h1234, 32'h0, model_lat(2'b00, 16'h0000, 16'h1234), 0, "zero_m");

        // Reset in the third RUN cycle, with a simultaneous input request.
        mode = 2'b00; M = 16'h7FFF; Q = 16'h8001; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        clr_n    = 1'b0;
        in_valid = 1'b1;
        tick;
        clr_n    = 1'b1;
        in_valid = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (out_valid) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);

        for (int k = 0; k < 24; k++) begin
            md = 2'($urandom_range(0, 3));
            m  = 16'($urandom);
            q  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                n   = lanes_of(md);
                len = 16 / n;
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 1) == 1) m = m & ~lane_mask(len, i);
                    else q = q & ~lane_mask(len, i);
                end
            end
            run_op(md, m, q, model(md, m, q), model_lat(md, m, q),
                   int'($urandom_range(0, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
